fetch_align: RTL
================

# fetch_align

Instruction-fetch stage directly upstream of the decode stage. Issues word-aligned requests to instruction memory and realigns the returned 32-bit words into whole RV32IMFC instructions, including 16-bit compressed ones and 32-bit instructions that straddle a word boundary. Drives the IF/ID pipeline register (`ins`, `comp_sig`, `IF_ID_pres_addr`) and applies branch and trap redirects. Every empty slot is presented to decode as a bubble, `ins` = 0.

## Interface
- `ADDR_W`, 32, program-counter and memory address width.
- `RESET_PC`, 0, fetch address after reset; must be 2-byte aligned.

- `clk`  in  1  system clock
- `Rst`  in  1  asynchronous, active-high reset
- `hz`  in  1  decode hazard stall
- `dbg`  in  1  debug halt
- `mem_hold`  in  1  data-memory hold
- `f_stall`  in  1  FPU stall
- `branch`  in  1  decode's branch/jump taken
- `branoff`  in  ADDR_W  absolute branch target
- `trigger_trap`  in  1  trap entry
- `trap_addr`  in  ADDR_W  trap/return target
- `imem_req`  out  1  memory request strobe
- `imem_addr`  out  ADDR_W  request address, bits [1:0] = 0
- `imem_rdata`  in  32  returned word
- `imem_valid`  in  1  `imem_rdata` valid this cycle
- `ins`  out  32  IF/ID instruction; compressed instructions occupy [15:0] with [31:16] = 0
- `comp_sig`  out  1  `ins` is a 16-bit instruction
- `IF_ID_pres_addr`  out  ADDR_W  address of `ins`

## Operation
- **Internal state**
  - `pc`: next instruction address.
  - `hbuf[15:0]` and `hbuf_v`: upper halfword of the last word, which lives at address `{pc[ADDR_W-1:2],2'b10}`.
  - `wbuf[31:0]` and `wbuf_v`: one staged memory response.
  - `pend`: one request outstanding.
  - `drop`: discard the next response.
- **Holds**
  - `hold` = `hz | dbg | mem_hold | f_stall`.
  - While `hold` is set, the IF/ID outputs keep their values.
- **Request rule**
  - Only one request may be outstanding.
  - The block issues a request when `!pend`, `!wbuf_v`, and the instruction at `pc` needs a word it does not yet hold.
  - `imem_req` is a 1-cycle pulse. `imem_addr` = word address of the needed word.
  - A response with `pend` set loads `wbuf` (skipped if `drop` is set) and clears `pend` and `drop`.
  - `imem_valid` while `!pend` is ignored.
- **Assembly rule** (evaluated when `!hold`)
  - A halfword is compressed iff bits [1:0] ≠ 2'b11.
  - `pc[1]=0`, `wbuf_v` set:
    - Low half compressed: emit the low half; move the upper half to `hbuf` and set `hbuf_v`; `pc += 2`.
    - Otherwise: emit the whole word; `pc += 4`.
    - In both cases `wbuf_v` is cleared.
  - `pc[1]=1`, `hbuf_v` set:
    - `hbuf` compressed: emit it; clear `hbuf_v`; `pc += 2`.
    - Otherwise wait for `wbuf_v`, then emit `{wbuf[15:0], hbuf}`; `wbuf[31:16]` goes to `hbuf`; clear `wbuf_v`; `pc += 4`.
  - `pc[1]=1`, `hbuf_v` clear (after a redirect to an odd halfword): fetch the word; its lower half is discarded and its upper half loads `hbuf`.
  - An emit writes `ins`, `comp_sig` and `IF_ID_pres_addr = pc`.
  - When `!hold` and nothing can be emitted, `ins` <= 0 and `comp_sig` <= 0.
- **Redirect**
  - Priority order: `trigger_trap` > `branch`.
  - `trigger_trap` is honoured unless `dbg`. `branch` is honoured only when `!hold`.
  - On redirect:
    - `pc` <= target (`trap_addr` or `branoff`); bit 0 is forced to 0.
    - `hbuf_v` and `wbuf_v` are cleared.
    - `ins` <= 0 and `comp_sig` <= 0.
    - `drop` <= `pend`, unless `imem_valid` arrives in the same cycle, in which case that word is discarded and `drop` <= 0.
  - Nothing is emitted in the redirect cycle.
- **Reset** (asynchronous)
  - `pc` = `RESET_PC`; `ins` = 0; `comp_sig` = 0; `IF_ID_pres_addr` = 0; `imem_req` = 0; `imem_addr` = 0.
  - `hbuf_v`, `wbuf_v`, `pend` and `drop` all = 0.
  - Reset asserted mid-request abandons the request; a late `imem_valid` is ignored because `pend` = 0.

## Timing
- `imem_req` and `imem_addr` are registered and assert the cycle after the need is detected.
- Memory latency is ≥1 cycle, variable.
- A word returned at edge E can emit at edge E+1 (data in `wbuf` and `!hold`).
- Sequential fetch with 1-cycle memory gives one 32-bit instruction every 3 cycles: request, response, emit.
- A compressed instruction following from `hbuf` emits the next cycle with no memory access.
- Branch at edge B: the first instruction from the target is in `ins` no earlier than B+3 with a 1-cycle memory.
- `hold` never blocks a memory response; it is staged in `wbuf`.

## Test plan
- **Reset:** assert `Rst` asynchronously mid-cycle → `ins`=0, `imem_req`=0 immediately. Release → first request `imem_addr`=`RESET_PC`.
- **Plain 32-bit stream:** words 0x00500093, 0x00A00113 at 0x0, 0x4 → `ins` shows them in order with `comp_sig`=0 and `IF_ID_pres_addr` 0x0, 0x4.
- **Mixed and straddling:**
  - Word0 = 0x00934505: c.li at 0x0, then the low half of a 32-bit instruction at 0x2.
  - Word1 = 0x....0093: supplies its upper half.
  - Expected: `ins`=0x00004505 with `comp_sig`=1 at 0x0, then `ins`=0x00930093 with `comp_sig`=0 at 0x2. Only two memory requests are made.
- **Branch with in-flight fetch:** `branch`=1, `branoff`=0x40 while `pend`=1 → the stale response is dropped, next `imem_addr`=0x40, `ins`=0 until the target instruction arrives.
- **Hold:** `hz`=1 for 4 cycles while a response arrives → `ins` is unchanged, the word is staged, and no new request is made. The word emits the cycle after `hz` falls.
- **Trap vs. branch:** `trigger_trap` and `branch` in the same cycle with `trap_addr`=0x100 → `pc`=0x100. Redirect to 0x102 → only the upper half of word 0x100 is used.

Source files
------------

// File: rtl/fetch_align.sv
// fetch_align
// -----------
// Instruction-fetch stage feeding the IF/ID pipeline register. It issues
// word-aligned requests to instruction memory, one at a time, and
// reassembles the returned 32-bit words into whole instructions. 16-bit
// compressed instructions and 32-bit instructions that straddle a word
// boundary are both handled. Every empty slot goes to decode as a bubble
// (ins = 0). Branch and trap redirects restart fetch at a new address.
//
// Ports
//   clk, Rst         clock and asynchronous active-high reset
//   hz, dbg,         hold sources; while any is set the IF/ID outputs keep
//   mem_hold,        their values
//   f_stall
//   branch, branoff  decode's taken branch and its absolute target
//   trigger_trap,    trap entry/return and its target (ignored under dbg)
//   trap_addr
//   imem_req         one-cycle request strobe (registered)
//   imem_addr        word-aligned request address (registered)
//   imem_rdata       returned word
//   imem_valid       imem_rdata is valid this cycle
//   ins              IF/ID instruction; compressed ones sit in [15:0]
//   comp_sig         ins is a 16-bit instruction
//   IF_ID_pres_addr  address of ins
module fetch_align #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              hz,
  input  logic              dbg,
  input  logic              mem_hold,
  input  logic              f_stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branoff,
  input  logic              trigger_trap,
  input  logic [ADDR_W-1:0] trap_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       ins,
  output logic              comp_sig,
  output logic [ADDR_W-1:0] IF_ID_pres_addr
);

  // Fetch state
  logic [ADDR_W-1:0] pc;      // address of the next instruction to emit
  logic [15:0]       hbuf;    // upper halfword of the last word, at {pc[W-1:2],2'b10}
  logic              hbuf_v;
  logic [31:0]       wbuf;    // one staged memory response
  logic              wbuf_v;
  logic              pend;    // a request is outstanding
  logic              drop;    // the outstanding response belongs to an abandoned path

  // Hold and redirect decode
  logic              hold;
  logic              take_trap;
  logic              take_branch;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              resp;

  assign hold        = hz | dbg | mem_hold | f_stall;
  assign take_trap   = trigger_trap & ~dbg;
  assign take_branch = branch & ~hold & ~take_trap;
  assign redirect    = take_trap | take_branch;
  assign target      = take_trap ? trap_addr : branoff;
  assign resp        = imem_valid & pend;

  // A halfword starts a compressed instruction unless its low bits are 2'b11
  logic lo_comp;
  logic hb_comp;
  assign lo_comp = (wbuf[1:0] != 2'b11);
  assign hb_comp = (hbuf[1:0] != 2'b11);

  logic [ADDR_W-1:0] word_pc;
  logic [ADDR_W-1:0] word_next;
  assign word_pc   = {pc[ADDR_W-1:2], 2'b00};
  assign word_next = word_pc + ADDR_W'(4);

  // Which word (if any) the instruction at pc still needs. A staged word
  // always covers the current need, so nothing is requested while wbuf_v.
  logic              need;
  logic [ADDR_W-1:0] need_addr;
  logic              issue;

  always_comb begin
    need      = 1'b0;
    need_addr = word_pc;
    if (!wbuf_v) begin
      if (!pc[1]) begin
        need = 1'b1;                  // aligned start: word at pc
      end else if (!hbuf_v) begin
        need = 1'b1;                  // odd start after redirect: word holding pc
      end else if (!hb_comp) begin
        need      = 1'b1;             // straddling 32-bit: following word
        need_addr = word_next;
      end
    end
  end

  // A request decided from pre-redirect state would fetch the wrong path
  assign issue = need & ~pend & ~redirect;

  // Instruction assembly from hbuf/wbuf
  logic              emit;
  logic [31:0]       emit_ins;
  logic              emit_comp;
  logic [ADDR_W-1:0] pc_inc;
  logic              hbuf_load;
  logic [15:0]       hbuf_load_val;
  logic              hbuf_clr;
  logic              wbuf_clr;

  always_comb begin
    emit          = 1'b0;
    emit_ins      = 32'h0;
    emit_comp     = 1'b0;
    pc_inc        = '0;
    hbuf_load     = 1'b0;
    hbuf_load_val = wbuf[31:16];
    hbuf_clr      = 1'b0;
    wbuf_clr      = 1'b0;
    if (!pc[1]) begin
      if (wbuf_v) begin
        emit     = 1'b1;
        wbuf_clr = 1'b1;
        if (lo_comp) begin
          emit_ins  = {16'h0, wbuf[15:0]};
          emit_comp = 1'b1;
          pc_inc    = ADDR_W'(2);
          hbuf_load = 1'b1;           // upper half is the next instruction start
        end else begin
          emit_ins = wbuf;
          pc_inc   = ADDR_W'(4);
        end
      end
    end else if (hbuf_v) begin
      if (hb_comp) begin
        emit      = 1'b1;
        emit_ins  = {16'h0, hbuf};
        emit_comp = 1'b1;
        pc_inc    = ADDR_W'(2);
        hbuf_clr  = 1'b1;
      end else if (wbuf_v) begin
        emit      = 1'b1;
        emit_ins  = {wbuf[15:0], hbuf};
        pc_inc    = ADDR_W'(4);
        hbuf_load = 1'b1;             // leftover upper half stays buffered
        wbuf_clr  = 1'b1;
      end
    end else if (wbuf_v) begin
      // Odd redirect target: the low half of the word precedes pc and is dropped
      hbuf_load = 1'b1;
      wbuf_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pc              <= RESET_PC;
      hbuf            <= 16'h0;
      hbuf_v          <= 1'b0;
      wbuf            <= 32'h0;
      wbuf_v          <= 1'b0;
      pend            <= 1'b0;
      drop            <= 1'b0;
      imem_req        <= 1'b0;
      imem_addr       <= '0;
      ins             <= 32'h0;
      comp_sig        <= 1'b0;
      IF_ID_pres_addr <= '0;
    end else begin
      imem_req <= issue;
      if (issue) begin
        imem_addr <= need_addr;
      end

      if (redirect) begin
        pc       <= target & {{(ADDR_W-1){1'b1}}, 1'b0};
        hbuf_v   <= 1'b0;
        wbuf_v   <= 1'b0;
        ins      <= 32'h0;
        comp_sig <= 1'b0;
        if (resp) begin
          // The stale word lands right now: discard it and close the request
          pend <= 1'b0;
          drop <= 1'b0;
        end else begin
          drop <= pend;
        end
      end else begin
        if (!hold) begin
          if (emit) begin
            ins             <= emit_ins;
            comp_sig        <= emit_comp;
            IF_ID_pres_addr <= pc;
          end else begin
            ins      <= 32'h0;
            comp_sig <= 1'b0;
          end
          pc <= pc + pc_inc;
          if (hbuf_load) begin
            hbuf   <= hbuf_load_val;
            hbuf_v <= 1'b1;
          end else if (hbuf_clr) begin
            hbuf_v <= 1'b0;
          end
          if (wbuf_clr) begin
            wbuf_v <= 1'b0;
          end
        end

        // Responses are accepted regardless of hold and staged in wbuf
        if (issue) begin
          pend <= 1'b1;
        end else if (resp) begin
          pend <= 1'b0;
          drop <= 1'b0;
          if (!drop) begin
            wbuf   <= imem_rdata;
            wbuf_v <= 1'b1;
          end
        end
      end
    end
  end

endmodule
